// File: rtl/mdu_issue_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_issue_ctrl_if : ID-stage request, MDU handshake and status bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface mdu_issue_ctrl_if;
  logic        id_valid;
  logic [3:0]  id_md_type;
  logic [31:0] id_rs;
  logic [31:0] id_rt;
  logic        ex_flush;
  logic        mdu_busy;
  logic        mdu_start;
  logic [3:0]  mdu_type;
  logic [31:0] mdu_rs;
  logic [31:0] mdu_rt;
  logic        stall;
  logic        proto_err;
  logic [31:0] stall_cnt;

  modport slave (
    input  id_valid, id_md_type, id_rs, id_rt, ex_flush, mdu_busy,
    output mdu_start, mdu_type, mdu_rs, mdu_rt, stall, proto_err, stall_cnt
  );

  modport master (
    output id_valid, id_md_type, id_rs, id_rt, ex_flush, mdu_busy,
    input  mdu_start, mdu_type, mdu_rs, mdu_rt, stall, proto_err, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_issue_ctrl : issues MD ops to the MDU, stalls ID, checks busy protocol
// Revision 1.0
// ---------------------------------------------------------------------------
module mdu_issue_ctrl (
  input  wire logic         clk,
  input  wire logic         reset,
  mdu_issue_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [3:0] C_EXP_MUL = 4'd5;
  localparam logic [3:0] C_EXP_DIV = 4'd10;

  state_t      state_q, state_d;
  logic        mdu_start_q, mdu_start_d;
  logic [3:0]  mdu_type_q, mdu_type_d;
  logic [31:0] mdu_rs_q, mdu_rs_d;
  logic [31:0] mdu_rt_q, mdu_rt_d;
  logic [3:0]  exp_q, exp_d;
  logic        proto_err_q, proto_err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic md_req;
  logic stall;
  logic accept;
  logic is_mfx;

  always_comb begin
    md_req = bus.id_valid && (bus.id_md_type >= 4'd1) && (bus.id_md_type <= 4'd8);
    // ex_flush deliberately does not mask stall: ID must stay frozen regardless
    stall  = md_req && ((state_q != S_IDLE) || bus.mdu_busy);
    accept = md_req && !stall && !bus.ex_flush;
    is_mfx = (bus.id_md_type == 4'd5) || (bus.id_md_type == 4'd6);

    state_d     = state_q;
    mdu_start_d = 1'b0;
    mdu_type_d  = mdu_type_q;
    mdu_rs_d    = mdu_rs_q;
    mdu_rt_d    = mdu_rt_q;
    exp_d       = exp_q;
    proto_err_d = proto_err_q;
    stall_cnt_d = stall_cnt_q;

    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept && !is_mfx) begin
          mdu_type_d  = bus.id_md_type;
          mdu_rs_d    = bus.id_rs;
          mdu_rt_d    = bus.id_rt;
          mdu_start_d = 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (mdu_type_q <= 4'd4) begin
          exp_d   = (mdu_type_q <= 4'd2) ? C_EXP_MUL : C_EXP_DIV;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.mdu_busy) begin
          exp_d   = exp_q - 4'd1;
          state_d = S_RUN;
        end else begin
          proto_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.mdu_busy) begin
          if (exp_q == 4'd0) begin
            proto_err_d = 1'b1;
          end else begin
            exp_d = exp_q - 4'd1;
          end
        end else begin
          if (exp_q != 4'd0) begin
            proto_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mdu_start_q <= 1'b0;
      mdu_type_q  <= 4'd0;
      mdu_rs_q    <= 32'd0;
      mdu_rt_q    <= 32'd0;
      exp_q       <= 4'd0;
      proto_err_q <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      mdu_start_q <= mdu_start_d;
      mdu_type_q  <= mdu_type_d;
      mdu_rs_q    <= mdu_rs_d;
      mdu_rt_q    <= mdu_rt_d;
      exp_q       <= exp_d;
      proto_err_q <= proto_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.mdu_start = mdu_start_q;
  assign bus.mdu_type  = mdu_type_q;
  assign bus.mdu_rs    = mdu_rs_q;
  assign bus.mdu_rt    = mdu_rt_q;
  assign bus.stall     = stall;
  assign bus.proto_err = proto_err_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mdu_issue_ctrl : directed stimulus with a start-pulse scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mdu_issue_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_issue_ctrl_if bus ();

  mdu_issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  t;
    logic [31:0] rs;
    logic [31:0] rt;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   fault_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // MDU model: busy rises the cycle after mdu_start and stays high for the op length
  initial begin
    int left;
    int len;
    left = 0;
    bus.mdu_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset !== 1'b1) begin
        left = 0;
        bus.mdu_busy = 1'b0;
      end else begin
        if (left > 0) begin
          bus.mdu_busy = 1'b1;
          left--;
        end else begin
          bus.mdu_busy = 1'b0;
        end
        if (bus.mdu_start === 1'b1) begin
          case (bus.mdu_type)
            4'd1, 4'd2: len = 5;
            4'd3, 4'd4: len = 10;
            default:    len = 0;
          endcase
          if (fault_len != 0 && len != 0) len = fault_len;
          left = len;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.mdu_start === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got type 0x%0h expected no start", bus.mdu_type);
        end else begin
          e = q.pop_front();
          chk("start_type", {28'd0, bus.mdu_type}, {28'd0, e.t});
          chk("start_rs", bus.mdu_rs, e.rs);
          chk("start_rt", bus.mdu_rt, e.rt);
          chk("start_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    exp_t e;
    bus.id_valid   = 1'b1;
    bus.id_md_type = t;
    bus.id_rs      = a;
    bus.id_rt      = b;
    stalls = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.stall === 1'b0) begin
        if (!(t == 4'd5 || t == 4'd6)) begin
          e.t = t; e.rs = a; e.rt = b; e.cyc = cyc + 1;
          q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.id_valid = 1'b0;
        return;
      end
      stalls++;
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: got stall for %0d cycles expected accept", stalls);
    bus.id_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_start"},  {31'd0, bus.mdu_start}, 32'd0);
    chk({tag, "_type"},   {28'd0, bus.mdu_type}, 32'd0);
    chk({tag, "_rs"},     bus.mdu_rs, 32'd0);
    chk({tag, "_rt"},     bus.mdu_rt, 32'd0);
    chk({tag, "_perr"},   {31'd0, bus.proto_err}, 32'd0);
    chk({tag, "_scnt"},   bus.stall_cnt, 32'd0);
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.id_valid   = 1'b0;
    bus.id_md_type = 4'd0;
    bus.id_rs      = 32'd0;
    bus.id_rt      = 32'd0;
    bus.ex_flush   = 1'b0;
    fault_len      = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("rst");
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    int s;

    // MULT 3 * -2 on a healthy MDU
    do_reset();
    issue(4'd1, 32'd3, 32'hFFFF_FFFE, s);
    chk("mult_stalls", s, 0);
    idle(9);
    chk("mult_perr", {31'd0, bus.proto_err}, 32'd0);
    chk("mult_rs_hold", bus.mdu_rs, 32'd3);
    chk("mult_rt_hold", bus.mdu_rt, 32'hFFFF_FFFE);
    issue(4'd5, 32'd0, 32'd0, s);
    chk("mult_then_idle", s, 0);

    // DIV then MFLO directly behind
    do_reset();
    issue(4'd3, 32'd100, 32'd7, s);
    issue(4'd6, 32'd0, 32'd0, s);
    chk("mflo_stalls", s, 12);
    chk("mflo_stall_cnt", bus.stall_cnt, 32'd12);
    chk("div_perr", {31'd0, bus.proto_err}, 32'd0);

    // MTHI then MFHI; MFHI must not overwrite the registered op
    do_reset();
    issue(4'd7, 32'h1234, 32'd0, s);
    issue(4'd5, 32'h9999, 32'h8888, s);
    chk("mfhi_stalls", s, 1);
    chk("mthi_stall_cnt", bus.stall_cnt, 32'd1);
    chk("mthi_type_hold", {28'd0, bus.mdu_type}, 32'd7);
    chk("mthi_rs_hold", bus.mdu_rs, 32'h1234);
    issue(4'd5, 32'd0, 32'd0, s);
    chk("mthi_idle_after", s, 0);
    chk("mthi_perr", {31'd0, bus.proto_err}, 32'd0);

    // faulty MDU: busy too short, then sticky across a clean op
    do_reset();
    fault_len = 3;
    issue(4'd2, 32'd5, 32'd6, s);
    idle(8);
    chk("short_busy_perr", {31'd0, bus.proto_err}, 32'd1);
    fault_len = 0;
    issue(4'd1, 32'd1, 32'd2, s);
    idle(9);
    chk("perr_sticky", {31'd0, bus.proto_err}, 32'd1);

    // faulty MDU: busy too long
    do_reset();
    fault_len = 7;
    issue(4'd1, 32'd4, 32'd4, s);
    idle(12);
    chk("long_busy_perr", {31'd0, bus.proto_err}, 32'd1);

    // ex_flush in the accept cycle
    do_reset();
    issue(4'd8, 32'hAA, 32'hBB, s);
    idle(3);
    bus.id_valid   = 1'b1;
    bus.id_md_type = 4'd1;
    bus.id_rs      = 32'd9;
    bus.id_rt      = 32'd9;
    bus.ex_flush   = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    bus.ex_flush = 1'b0;
    bus.id_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_start", {31'd0, bus.mdu_start}, 32'd0);
    chk("flush_type_hold", {28'd0, bus.mdu_type}, 32'd8);
    chk("flush_rs_hold", bus.mdu_rs, 32'hAA);
    @(posedge clk);
    #1;
    issue(4'd6, 32'd0, 32'd0, s);
    chk("flush_idle_after", s, 0);

    // asynchronous reset in the middle of a DIV
    do_reset();
    issue(4'd3, 32'h55, 32'h66, s);
    bus.id_valid   = 1'b1;
    bus.id_md_type = 4'd6;
    repeat (5) @(posedge clk);
    #3;
    bus.id_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_zero_outputs("async");
    chk("async_stall", {31'd0, bus.stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    issue(4'd7, 32'd1, 32'd2, s);
    chk("post_reset_idle", s, 0);
    idle(3);

    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
